// File: rtl/idma_boundary_split_midend_pkg.sv
// Shared types for the boundary-split midend: 1D burst request, status meta
// and the splitter state encoding.
package idma_boundary_split_midend_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned LenWidth  = 32;
  localparam int unsigned OptWidth  = 8;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [LenWidth-1:0]  len_t;

  // opt stands in for the opaque remainder of the request; it rides along untouched
  typedef struct packed {
    addr_t               src;
    addr_t               dst;
    len_t                num_bytes;
    logic [OptWidth-1:0] opt;
  } burst_req_t;

  typedef struct packed {
    logic trans_complete;
    logic backend_idle;
  } meta_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } split_state_e;

endpackage

// File: rtl/idma_boundary_split_midend_fifo.sv
// Small synchronous FIFO with the fifo_v3 handshake (push/pop with full/empty);
// holds the piece count of each fully issued request until it completes.
module idma_boundary_split_midend_fifo #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DEPTH        = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic [AddrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]       usage_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop, bypass;

  function automatic logic [AddrW-1:0] incr(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (usage_q == CntW'(DEPTH));
  assign empty_o = (usage_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & (~empty_o | (FALL_THROUGH & push_i));
  // In fall-through mode a push straight into a pop on an empty FIFO never lands in memory
  assign bypass  = FALL_THROUGH & empty_o & do_push & do_pop;
  assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else if (!bypass) begin
      if (do_push) wr_ptr_q <= incr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= incr(rd_ptr_q);
      if (do_push && !do_pop)      usage_q <= usage_q + 1'b1;
      else if (!do_push && do_pop) usage_q <= usage_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/idma_boundary_split_midend.sv
// Cuts each 1D burst at every SplitWidth-aligned boundary of its in-region
// address and merges downstream completions back into one pulse per request.
module idma_boundary_split_midend
  import idma_boundary_split_midend_pkg::*;
#(
  parameter int unsigned SplitWidth     = 32'h400,
  parameter logic [31:0] DmaRegionStart = 32'h0000_0000,
  parameter logic [31:0] DmaRegionEnd   = 32'h1000_0000,
  parameter int unsigned PieceCntWidth  = 16,
  parameter int unsigned TransFifoDepth = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  burst_req_t   burst_req_i,
  input  logic         valid_i,
  output logic         ready_o,
  output meta_t        meta_o,
  output burst_req_t   burst_req_o,
  output logic         valid_o,
  input  logic         ready_i,
  input  meta_t        meta_i,
  output split_state_e dbg_state
);

  localparam int unsigned SplitLog = $clog2(SplitWidth);
  typedef logic [PieceCntWidth-1:0] piece_cnt_t;
  localparam piece_cnt_t CntAlmostMax = {{(PieceCntWidth-1){1'b1}}, 1'b0};

  split_state_e state_q, state_d;
  burst_req_t   cur_q;
  logic         key_src_q;
  piece_cnt_t   cnt_q, done_cnt_q, done_cnt_next, fifo_head;
  logic         tc_q, idle_q;
  logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
  addr_t        key;
  len_t         room, piece_bytes;
  logic         split, last_piece, piece_hs, accept;

  function automatic logic in_region(input addr_t a);
    return (a - DmaRegionStart) < (DmaRegionEnd - DmaRegionStart);
  endfunction

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // once valid_o rises, valid_o and burst_req_o hold until ready_i is seen.
  always_comb begin
    key         = key_src_q ? cur_q.src : cur_q.dst;
    room        = len_t'(SplitWidth) - len_t'(key[SplitLog-1:0]);
    piece_bytes = (cur_q.num_bytes < room) ? cur_q.num_bytes : room;
    last_piece  = (cur_q.num_bytes == piece_bytes);
    split       = (state_q == SPLIT);
    // Last piece waits for a free count slot, so the request is never issued unpaired
    valid_o     = split & ~(last_piece & fifo_full);
    piece_hs    = valid_o & ready_i;
    ready_o     = ~split | (piece_hs & last_piece);
    accept      = valid_i & ready_o;
    fifo_push   = piece_hs & last_piece;
    burst_req_o = '0;
    if (split) begin
      burst_req_o           = cur_q;
      burst_req_o.num_bytes = piece_bytes;
    end
    state_d = state_q;
    if (accept)         state_d = SPLIT;
    else if (fifo_push) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q     <= '0;
      key_src_q <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      cur_q     <= burst_req_i;
      key_src_q <= in_region(burst_req_i.src);
      cnt_q     <= '0;
    end else if (piece_hs) begin
      cur_q.src       <= cur_q.src + piece_bytes;
      cur_q.dst       <= cur_q.dst + piece_bytes;
      cur_q.num_bytes <= cur_q.num_bytes - piece_bytes;
      cnt_q           <= cnt_q + 1'b1;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) piece_hs |-> (cnt_q != CntAlmostMax));

  idma_boundary_split_midend_fifo #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (PieceCntWidth),
    .DEPTH        (TransFifoDepth)
  ) i_cnt_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (cnt_q + 1'b1),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (fifo_head)
  );

  // Completions may arrive before the owning request's count is pushed; they accumulate
  always_comb begin
    done_cnt_next = done_cnt_q + piece_cnt_t'(meta_i.trans_complete);
    fifo_pop      = ~fifo_empty & (done_cnt_next == fifo_head);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_cnt_q <= '0;
      tc_q       <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      done_cnt_q <= fifo_pop ? '0 : done_cnt_next;
      tc_q       <= fifo_pop;
      idle_q     <= meta_i.backend_idle & ~split & fifo_empty;
    end
  end

  always_comb begin
    meta_o                = '0;
    meta_o.trans_complete = tc_q;
    meta_o.backend_idle   = idle_q;
  end

  assign dbg_state = state_q;

endmodule
